babbage_sweep_seq: RTL and testbench

Sweep sequencer for the Babbage difference engine: accepts a range command `[first, last]`, drives the engine's `start`/`i` handshake once per `n`, and captures each `ans` on `done_tick`. Each captured result goes out, tagged with its `n`, through a small FIFO with a valid/ready stream. Sits between the host/command side and the engine; it is both the engine's upstream driver and its downstream consumer.

---
 rtl/babbage_pkg.sv | 29 ++
 rtl/babbage_result_fifo.sv | 55 +++++
 rtl/babbage_sweep_seq.sv | 103 ++++++++++
 tb/tb_babbage_sweep_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/babbage_pkg.sv
// Shared types and constants for the Babbage sweep sequencer and its engine.
// The polynomial constants seed the engine's difference registers: f(0), g(1), h(2), step.
package babbage_pkg;

  localparam int unsigned NW_DEFAULT = 6;
  localparam int unsigned DW_DEFAULT = 18;

  localparam int unsigned F0 = 1;
  localparam int unsigned G1 = 5;
  localparam int unsigned H2 = 10;
  localparam int unsigned C  = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [NW_DEFAULT-1:0] n;
    logic [DW_DEFAULT-1:0] data;
    logic                  last;
  } result_entry_t;

  function automatic int unsigned entry_width(input int unsigned nw, input int unsigned dw);
    return nw + dw + 1;
  endfunction

endpackage

// File: rtl/babbage_result_fifo.sv
// Synchronous result FIFO; head data reads as zero while empty so idle outputs stay clean.
module babbage_result_fifo
  import babbage_pkg::*;
#(
  parameter int unsigned Width = entry_width(NW_DEFAULT, DW_DEFAULT),
  parameter int unsigned Depth = 4,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [Aw:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [Aw:0] DepthCnt = Depth[Aw:0];

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wptr_q, rptr_q;
  logic [Aw:0]      count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/babbage_sweep_seq.sv
// Sweep sequencer: walks n from first to last, runs one engine job per n and
// queues each tagged result for the downstream valid/ready stream.
module babbage_sweep_seq
  import babbage_pkg::*;
#(
  parameter int unsigned NW         = NW_DEFAULT,
  parameter int unsigned DW         = DW_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [NW-1:0] cmd_first,
  input  logic [NW-1:0] cmd_last,
  output logic          eng_start,
  output logic [NW-1:0] eng_i,
  input  logic          eng_ready,
  input  logic          eng_done_tick,
  input  logic [DW-1:0] eng_ans,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] out_n,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned EW = entry_width(NW, DW);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  seq_state_e    state_q;
  logic [NW-1:0] n_q, last_q;
  logic          down_q;

  logic          at_last, push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] push_data, head;

  assign at_last   = (n_q == last_q);
  assign cmd_ready = (state_q == StIdle);
  assign eng_i     = n_q;
  // Holding start off while full is what guarantees a later push always has room.
  assign eng_start = (state_q == StIssue) && eng_ready && !fifo_full;
  assign push      = (state_q == StWait) && eng_done_tick;
  assign push_data = {n_q, eng_ans, at_last};
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != StIdle) || (fifo_count != '0);

  assign {out_n, out_data, out_last} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      last_q  <= '0;
      down_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            n_q     <= cmd_first;
            last_q  <= cmd_last;
            down_q  <= (cmd_first > cmd_last);
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (eng_start) state_q <= StWait;
        end
        StWait: begin
          if (eng_done_tick) begin
            if (at_last) begin
              state_q <= StIdle;
            end else begin
              n_q     <= down_q ? (n_q - 1'b1) : (n_q + 1'b1);
              state_q <= StIssue;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  babbage_result_fifo #(
    .Width(EW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(push_data),
    .pop  (pop),
    .rdata(head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_babbage_sweep_seq.sv
// Directed bench for babbage_sweep_seq with a behavioural difference engine and
// an expected-result queue checked on every output handshake.
module tb_babbage_sweep_seq;
  import babbage_pkg::*;

  localparam int unsigned NW = 6;
  localparam int unsigned DW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [NW-1:0] cmd_first, cmd_last;
  logic          eng_start, eng_ready, eng_done_tick;
  logic [NW-1:0] eng_i;
  logic [DW-1:0] eng_ans;
  logic          out_valid, out_ready, out_last, busy;
  logic [NW-1:0] out_n;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  babbage_sweep_seq #(
    .NW(NW),
    .DW(DW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_first    (cmd_first),
    .cmd_last     (cmd_last),
    .eng_start    (eng_start),
    .eng_i        (eng_i),
    .eng_ready    (eng_ready),
    .eng_done_tick(eng_done_tick),
    .eng_ans      (eng_ans),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_n        (out_n),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy)
  );

  // Engine model: done_tick asserts i+2 edges after the start edge.
  logic          e_busy;
  logic [NW-1:0] e_n, e_k;
  logic [NW:0]   e_cnt;
  logic [31:0]   e_f, e_g, e_h;

  assign eng_ready = !e_busy;
  assign eng_ans   = e_f[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_busy        <= 1'b0;
      eng_done_tick <= 1'b0;
      e_n           <= '0;
      e_k           <= '0;
      e_cnt         <= '0;
      e_f           <= '0;
      e_g           <= '0;
      e_h           <= '0;
    end else begin
      eng_done_tick <= 1'b0;
      if (!e_busy && eng_start) begin
        e_busy <= 1'b1;
        e_n    <= eng_i;
        e_k    <= '0;
        e_cnt  <= {1'b0, eng_i} + 1'b1;
        e_f    <= F0;
        e_g    <= G1;
        e_h    <= H2;
      end else if (e_busy) begin
        if (e_k < e_n) begin
          e_f <= e_f + e_g;
          e_g <= e_g + e_h;
          e_h <= e_h + C;
          e_k <= e_k + 1'b1;
        end
        if (e_cnt == '0) begin
          e_busy        <= 1'b0;
          eng_done_tick <= 1'b1;
        end else begin
          e_cnt <= e_cnt - 1'b1;
        end
      end
    end
  end

  int            n_cmp = 0;
  int            n_mis = 0;
  int            n_starts = 0;
  result_entry_t exp_q[$];

  function automatic logic [DW-1:0] f_ref(input int n);
    int unsigned v;
    v = n * n * n + 2 * n * n + 2 * n + 1;
    return v[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    result_entry_t e;
    @(negedge clk);
    if (eng_start) n_starts++;
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_mis++;
        $error("FAIL out_spurious: observed n=%0d data=%0d expected no output", out_n, out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_n", 32'(out_n), 32'(e.n));
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_last", 32'(out_last), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    check({tag, "_eng_i"}, 32'(eng_i), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_n"}, 32'(out_n), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic send_cmd(input int first, input int last);
    int            k = 0;
    int            n;
    result_entry_t e;
    while (!cmd_ready && k < 300) begin
      tick();
      k++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_first = NW'(first);
    cmd_last  = NW'(last);
    cmd_valid = 1'b1;
    n = first;
    forever begin
      e.n    = NW'(n);
      e.data = f_ref(n);
      e.last = (n == last);
      exp_q.push_back(e);
      if (n == last) break;
      n += (first > last) ? -1 : 1;
    end
    tick();
    cmd_valid = 1'b0;
    check("cmd_ready_drop", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int base;
    int k;
    cmd_valid = 1'b0;
    cmd_first = '0;
    cmd_last  = '0;
    out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #1 check_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single value
    send_cmd(3, 3);
    wait_idle("single", 300);

    // Ascending sweep; start follows acceptance by one cycle
    send_cmd(0, 5);
    check("asc_first_start", 32'(eng_start), 32'd1);
    check("asc_first_eng_i", 32'(eng_i), 32'd0);
    wait_idle("asc", 500);

    // Descending sweep
    send_cmd(4, 2);
    check("desc_first_eng_i", 32'(eng_i), 32'd4);
    wait_idle("desc", 500);

    // Backpressure: four results buffered, fifth job held back
    out_ready = 1'b0;
    base = n_starts;
    send_cmd(0, 7);
    repeat (150) tick();
    check("bp_starts", 32'(n_starts - base), 32'd4);
    check("bp_eng_start", 32'(eng_start), 32'd0);
    check("bp_eng_i", 32'(eng_i), 32'd4);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head_n", 32'(out_n), 32'd0);
    check("bp_head_data", 32'(out_data), 32'd1);
    check("bp_head_last", 32'(out_last), 32'd0);
    check("bp_queued", 32'(exp_q.size()), 32'd8);
    out_ready = 1'b1;
    wait_idle("bp", 800);
    check("bp_total_starts", 32'(n_starts - base), 32'd8);

    // Max input
    send_cmd(63, 63);
    wait_idle("max", 300);

    // Reset during the WAIT of n=5
    base = n_starts;
    send_cmd(0, 10);
    k = 0;
    while ((n_starts - base) < 6 && k < 300) begin
      tick();
      k++;
    end
    tick();
    check("mid_eng_i", 32'(eng_i), 32'd5);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check_reset("mid");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send_cmd(1, 1);
    wait_idle("post_rst", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
